// File: rtl/switch_conditioner.sv
// Slide-switch conditioner: synchroniser + counter debounce FSM producing a clean level, edge pulses and core run/halt.
// Optional single-step pushbutton path enabled by defining SWITCH_STEP_EN.

module switch_conditioner_deb #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o,
  output logic level_nxt_c,
  output logic rise_nxt_c
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // State, counter, synchroniser and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Any reversion while checking drops back to the idle state without a pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      IDLE_LO: begin
        if (sync) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!sync) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!sync) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (sync) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE_LO;
    endcase
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  assign level_o     = level_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign busy_o      = busy_q;
  assign level_nxt_c = level_d;
  assign rise_nxt_c  = rise_d;

endmodule

module switch_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic clock,
  input  logic reset,
  input  logic switch_raw,
`ifdef SWITCH_STEP_EN
  input  logic step_raw,
`endif
  output logic switch_level,
  output logic switch_rise,
  output logic switch_fall,
  output logic busy,
  output logic hold
);

  logic sw_level_nxt;
  logic sw_rise_nxt_unused;
  logic hold_q, hold_d;

  switch_conditioner_deb #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_deb (
    .clock      (clock),
    .reset      (reset),
    .raw_i      (switch_raw),
    .level_o    (switch_level),
    .rise_o     (switch_rise),
    .fall_o     (switch_fall),
    .busy_o     (busy),
    .level_nxt_c(sw_level_nxt),
    .rise_nxt_c (sw_rise_nxt_unused)
  );

`ifdef SWITCH_STEP_EN
  logic st_rise_nxt;
  logic st_level_unused, st_rise_unused, st_fall_unused, st_busy_unused, st_level_nxt_unused;

  switch_conditioner_deb #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_deb (
    .clock      (clock),
    .reset      (reset),
    .raw_i      (step_raw),
    .level_o    (st_level_unused),
    .rise_o     (st_rise_unused),
    .fall_o     (st_fall_unused),
    .busy_o     (st_busy_unused),
    .level_nxt_c(st_level_nxt_unused),
    .rise_nxt_c (st_rise_nxt)
  );

  // A step grant releases the core for the single cycle the debounced step rise is registered
  assign hold_d = sw_level_nxt & ~st_rise_nxt;
`else
  assign hold_d = sw_level_nxt;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign hold = hold_q;

endmodule
